// File: rtl/rggen_axi4lite_bridge.sv
// rggen native bus -> AXI4-Lite master bridge, one outstanding transaction.
// Define RGGEN_AXI4LITE_BRIDGE_RESPONSE_REG_EN to register the response path (one extra cycle).
module rggen_axi4lite_bridge #(
  parameter int         ID_WIDTH        = 0,
  parameter int         ADDRESS_WIDTH   = 16,
  parameter int         BUS_WIDTH       = 32,
  parameter int         ID_VALUE        = 0,
  parameter logic [2:0] PROT_VALUE      = 3'b000,
  parameter int         ACTUAL_ID_WIDTH = (ID_WIDTH > 0) ? ID_WIDTH : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_bus_valid,
  input  logic [1:0]                 i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]   i_bus_address,
  input  logic [BUS_WIDTH-1:0]       i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]     i_bus_strobe,
  output logic                       o_bus_ready,
  output logic [1:0]                 o_bus_status,
  output logic [BUS_WIDTH-1:0]       o_bus_read_data,
  output logic                       o_awvalid,
  input  logic                       i_awready,
  output logic [ACTUAL_ID_WIDTH-1:0] o_awid,
  output logic [ADDRESS_WIDTH-1:0]   o_awaddr,
  output logic [2:0]                 o_awprot,
  output logic                       o_wvalid,
  input  logic                       i_wready,
  output logic [BUS_WIDTH-1:0]       o_wdata,
  output logic [BUS_WIDTH/8-1:0]     o_wstrb,
  input  logic                       i_bvalid,
  output logic                       o_bready,
  input  logic [ACTUAL_ID_WIDTH-1:0] i_bid,
  input  logic [1:0]                 i_bresp,
  output logic                       o_arvalid,
  input  logic                       i_arready,
  output logic [ACTUAL_ID_WIDTH-1:0] o_arid,
  output logic [ADDRESS_WIDTH-1:0]   o_araddr,
  output logic [2:0]                 o_arprot,
  input  logic                       i_rvalid,
  output logic                       o_rready,
  input  logic [ACTUAL_ID_WIDTH-1:0] i_rid,
  input  logic [1:0]                 i_rresp,
  input  logic [BUS_WIDTH-1:0]       i_rdata
);
  localparam logic [ACTUAL_ID_WIDTH-1:0] ID_CONST =
    (ID_WIDTH == 0) ? '0 : ACTUAL_ID_WIDTH'(ID_VALUE);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [BUS_WIDTH/8-1:0]   wstrb_q;
  logic                     b_hs;
  logic                     r_hs;
  logic                     unused_inputs;

  assign b_hs          = o_bready & i_bvalid;
  assign r_hs          = o_rready & i_rvalid;
  assign unused_inputs = ^{i_bid, i_rid, i_bus_access[1]};

  assign o_awid   = ID_CONST;
  assign o_arid   = ID_CONST;
  assign o_awprot = PROT_VALUE;
  assign o_arprot = PROT_VALUE;
  assign o_awaddr = addr_q;
  assign o_araddr = addr_q;
  assign o_wdata  = wdata_q;
  assign o_wstrb  = wstrb_q;

`ifdef RGGEN_AXI4LITE_BRIDGE_RESPONSE_REG_EN
  logic [1:0]           status_q;
  logic [BUS_WIDTH-1:0] rdata_q;

  assign o_bus_ready     = (state == RESP);
  assign o_bus_status    = status_q;
  assign o_bus_read_data = rdata_q;
`else
  assign o_bus_ready = b_hs | r_hs;

  always_comb begin
    o_bus_status    = 2'b00;
    o_bus_read_data = '0;
    if (b_hs) begin
      o_bus_status = i_bresp;
    end else if (r_hs) begin
      o_bus_status    = i_rresp;
      o_bus_read_data = i_rdata;
    end
  end
`endif

  // AW and W retire independently; bready/rready span the whole data phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      o_awvalid <= 1'b0;
      o_wvalid  <= 1'b0;
      o_bready  <= 1'b0;
      o_arvalid <= 1'b0;
      o_rready  <= 1'b0;
`ifdef RGGEN_AXI4LITE_BRIDGE_RESPONSE_REG_EN
      status_q  <= 2'b00;
      rdata_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_bus_valid) begin
            addr_q  <= i_bus_address;
            wdata_q <= i_bus_write_data;
            wstrb_q <= i_bus_strobe;
            if (i_bus_access[0]) begin
              state     <= WRITE;
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
              o_bready  <= 1'b1;
            end else begin
              state     <= READ;
              o_arvalid <= 1'b1;
              o_rready  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (i_awready) o_awvalid <= 1'b0;
          if (i_wready)  o_wvalid  <= 1'b0;
          if (b_hs) begin
            o_awvalid <= 1'b0;
            o_wvalid  <= 1'b0;
            o_bready  <= 1'b0;
`ifdef RGGEN_AXI4LITE_BRIDGE_RESPONSE_REG_EN
            state     <= RESP;
            status_q  <= i_bresp;
            rdata_q   <= '0;
`else
            state     <= IDLE;
`endif
          end
        end
        READ: begin
          if (i_arready) o_arvalid <= 1'b0;
          if (r_hs) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b0;
`ifdef RGGEN_AXI4LITE_BRIDGE_RESPONSE_REG_EN
            state     <= RESP;
            status_q  <= i_rresp;
            rdata_q   <= i_rdata;
`else
            state     <= IDLE;
`endif
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Self-checking bench for rggen_axi4lite_bridge: AXI slave model with per-request delays,
// directed vector table, corner sequences and randomized requests against a latency/response model.
module tb_rggen_axi4lite_bridge;
`ifdef RGGEN_AXI4LITE_BRIDGE_RESPONSE_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_bus_valid;
  logic [1:0]  i_bus_access;
  logic [15:0] i_bus_address;
  logic [31:0] i_bus_write_data;
  logic [3:0]  i_bus_strobe;
  logic        o_bus_ready;
  logic [1:0]  o_bus_status;
  logic [31:0] o_bus_read_data;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;
  logic [0:0]  o_awid, o_arid, i_bid, i_rid;
  logic [15:0] o_awaddr, o_araddr;
  logic [2:0]  o_awprot, o_arprot;
  logic [31:0] o_wdata, i_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;

  rggen_axi4lite_bridge dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bus_valid(i_bus_valid), .i_bus_access(i_bus_access), .i_bus_address(i_bus_address),
    .i_bus_write_data(i_bus_write_data), .i_bus_strobe(i_bus_strobe),
    .o_bus_ready(o_bus_ready), .o_bus_status(o_bus_status), .o_bus_read_data(o_bus_read_data),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awprot(o_awprot),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bid(i_bid), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_arid(o_arid), .o_araddr(o_araddr), .o_arprot(o_arprot),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rid(i_rid), .i_rresp(i_rresp), .i_rdata(i_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // slave configuration for the current request
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  // slave/monitor state
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit          aw_done = 0, w_done = 0, b_pend = 0, r_pend = 0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, rdy_cnt = 0, stab_err = 0;
  bit          aw_hold = 0, w_hold = 0, ar_hold = 0;
  logic [15:0] aw_hold_addr = '0, ar_hold_addr = '0;
  logic [35:0] w_hold_pay = '0;
  logic [15:0] cap_awaddr = '0, cap_araddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [7:0]  cap_aw_side = '0, cap_ar_side = '0;

  // Drive slave outputs at negedge, then observe what the next posedge will sample.
  always @(negedge clk) begin
    i_awready = o_awvalid && (aw_cnt >= aw_dly);
    i_wready  = o_wvalid  && (w_cnt  >= w_dly);
    i_arready = o_arvalid && (ar_cnt >= ar_dly);
    i_bvalid  = b_pend && (b_cnt >= b_dly);
    i_bresp   = i_bvalid ? bresp_cfg : 2'b01;
    i_rvalid  = r_pend && (r_cnt >= r_dly);
    i_rresp   = i_rvalid ? rresp_cfg : 2'b10;
    i_rdata   = i_rvalid ? rdata_cfg : 32'hA5A5_5A5A;
    #1;
    if (!rst_n) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0;
    end else begin
      if (i_bvalid && o_bready) begin b_hs++; b_pend = 0; end
      else if (b_pend) b_cnt++;
      if (i_rvalid && o_rready) begin r_hs++; r_pend = 0; end
      else if (r_pend) r_cnt++;

      if (aw_hold && (!o_awvalid || o_awaddr !== aw_hold_addr)) stab_err++;
      if (w_hold && (!o_wvalid || {o_wstrb, o_wdata} !== w_hold_pay)) stab_err++;
      if (ar_hold && (!o_arvalid || o_araddr !== ar_hold_addr)) stab_err++;
      aw_hold = 0; w_hold = 0; ar_hold = 0;

      if (o_awvalid) begin
        if (i_awready) begin
          aw_hs++; aw_done = 1; aw_cnt = 0;
          cap_awaddr = o_awaddr; cap_aw_side = {4'd0, o_awid, o_awprot};
        end else begin
          aw_cnt++; aw_hold = 1; aw_hold_addr = o_awaddr;
        end
      end
      if (o_wvalid) begin
        if (i_wready) begin
          w_hs++; w_done = 1; w_cnt = 0; cap_wdata = o_wdata; cap_wstrb = o_wstrb;
        end else begin
          w_cnt++; w_hold = 1; w_hold_pay = {o_wstrb, o_wdata};
        end
      end
      if (o_arvalid) begin
        if (i_arready) begin
          ar_hs++; ar_cnt = 0; r_pend = 1; r_cnt = 0;
          cap_araddr = o_araddr; cap_ar_side = {4'd0, o_arid, o_arprot};
        end else begin
          ar_cnt++; ar_hold = 1; ar_hold_addr = o_araddr;
        end
      end
      if (aw_done && w_done) begin
        aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
      end
      if (o_bus_ready) rdy_cnt++;
    end
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [1:0]  exp_st;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: handshakes take (delay+1) cycles after valids rise one cycle after the request.
  function automatic int model_lat(input vec_t v);
    int m;
    m = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    return v.wr ? (3 + m + v.b_d + EXTRA) : (3 + v.ar_d + v.r_d + EXTRA);
  endfunction

  task automatic set_slave(input vec_t v);
    aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
    bresp_cfg = v.resp; rresp_cfg = v.resp; rdata_cfg = v.rdata;
  endtask

  task automatic do_req(input vec_t v, output logic [1:0] st, output logic [31:0] rd, output int lat);
    int cyc;
    bit got;
    @(negedge clk);
    i_bus_valid      = 1'b1;
    i_bus_access     = v.wr ? 2'b11 : 2'b10;
    i_bus_address    = v.addr;
    i_bus_write_data = v.wdata;
    i_bus_strobe     = v.strb;
    cyc = 0; got = 0; st = 2'b00; rd = '0; lat = -1;
    while (!got && cyc < 200) begin
      #1;
      if (o_bus_ready) begin
        got = 1; st = o_bus_status; rd = o_bus_read_data; lat = cyc + 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) check("bus_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    i_bus_valid  = 1'b0;
    i_bus_access = 2'b00;
    #2;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int a0, w0, r0, b0, rr0, y0, lat;
    logic [1:0]  st;
    logic [31:0] rd;
    a0 = aw_hs; w0 = w_hs; r0 = ar_hs; b0 = b_hs; rr0 = r_hs; y0 = rdy_cnt;
    set_slave(v);
    do_req(v, st, rd, lat);
    go_idle();
    check({tag, "_status"}, 64'(st), 64'(v.exp_st));
    check({tag, "_rdata"}, 64'(rd), 64'(v.exp_rd));
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_ready_pulses"}, 64'(rdy_cnt - y0), 64'd1);
    if (v.wr) begin
      check({tag, "_aw_count"}, 64'(aw_hs - a0), 64'd1);
      check({tag, "_w_count"}, 64'(w_hs - w0), 64'd1);
      check({tag, "_b_count"}, 64'(b_hs - b0), 64'd1);
      check({tag, "_ar_count"}, 64'(ar_hs - r0), 64'd0);
      check({tag, "_awaddr"}, 64'(cap_awaddr), 64'(v.addr));
      check({tag, "_wdata"}, 64'(cap_wdata), 64'(v.wdata));
      check({tag, "_wstrb"}, 64'(cap_wstrb), 64'(v.strb));
      check({tag, "_aw_id_prot"}, 64'(cap_aw_side), 64'd0);
    end else begin
      check({tag, "_ar_count"}, 64'(ar_hs - r0), 64'd1);
      check({tag, "_r_count"}, 64'(r_hs - rr0), 64'd1);
      check({tag, "_aw_count"}, 64'(aw_hs - a0), 64'd0);
      check({tag, "_araddr"}, 64'(cap_araddr), 64'(v.addr));
      check({tag, "_ar_id_prot"}, 64'(cap_ar_side), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    vec_t        v;
    vec_t        v2;
    int          a0, w0, r0, y0, lat1, lat2;
    logic [1:0]  st;
    logic [31:0] rd;
    bit          seen;

    vecs[0] = '{wr:0, addr:16'h0010, wdata:32'h0, strb:4'h0, aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:0,
                resp:2'b00, rdata:32'hDEAD_BEEF, exp_st:2'b00, exp_rd:32'hDEAD_BEEF, exp_lat:3};
    vecs[1] = '{wr:1, addr:16'h0020, wdata:32'h1234_5678, strb:4'b0011, aw_d:0, w_d:2, b_d:0, ar_d:0, r_d:0,
                resp:2'b10, rdata:32'h0, exp_st:2'b10, exp_rd:32'h0, exp_lat:5};
    vecs[2] = '{wr:1, addr:16'h0030, wdata:32'hCAFE_F00D, strb:4'b1111, aw_d:5, w_d:5, b_d:1, ar_d:0, r_d:0,
                resp:2'b00, rdata:32'h0, exp_st:2'b00, exp_rd:32'h0, exp_lat:9};
    vecs[3] = '{wr:0, addr:16'h0040, wdata:32'h0, strb:4'h0, aw_d:0, w_d:0, b_d:0, ar_d:1, r_d:2,
                resp:2'b11, rdata:32'hFFFF_FFFF, exp_st:2'b11, exp_rd:32'hFFFF_FFFF, exp_lat:6};
    vecs[4] = '{wr:0, addr:16'h0044, wdata:32'h0, strb:4'h0, aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:3,
                resp:2'b01, rdata:32'h0123_4567, exp_st:2'b01, exp_rd:32'h0123_4567, exp_lat:6};
    vecs[5] = '{wr:1, addr:16'h00FC, wdata:32'hA5A5_5A5A, strb:4'b1000, aw_d:3, w_d:0, b_d:2, ar_d:0, r_d:0,
                resp:2'b11, rdata:32'h0, exp_st:2'b11, exp_rd:32'h0, exp_lat:8};

    rst_n = 1'b0;
    i_bus_valid = 1'b0; i_bus_access = 2'b00; i_bus_address = '0;
    i_bus_write_data = '0; i_bus_strobe = '0;
    i_bid = 1'b0; i_rid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_bus_ready, o_bus_status, o_bus_read_data}),
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("const_id_prot", 64'({o_awid, o_awprot, o_arid, o_arprot}), 64'd0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      v.exp_lat = v.exp_lat + EXTRA;
      run_vec(v, $sformatf("vec%0d", i));
    end

    // back-to-back write then read, bus valid held across the ready cycle
    v  = '{wr:1, addr:16'h0100, wdata:32'h0BAD_CAFE, strb:4'b1111, aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:0,
           resp:2'b00, rdata:32'h7777_1111, exp_st:2'b00, exp_rd:32'h0, exp_lat:3};
    v2 = v;
    v2.wr = 0; v2.addr = 16'h0104; v2.exp_rd = 32'h7777_1111;
    a0 = aw_hs; w0 = w_hs; r0 = ar_hs; y0 = rdy_cnt;
    set_slave(v);
    do_req(v, st, rd, lat1);
    check("b2b_write_status", 64'(st), 64'd0);
    check("b2b_write_rdata", 64'(rd), 64'd0);
    do_req(v2, st, rd, lat2);
    check("b2b_read_rdata", 64'(rd), 64'h7777_1111);
    go_idle();
    check("b2b_write_latency", 64'(lat1), 64'(3 + EXTRA));
    check("b2b_read_latency", 64'(lat2), 64'(3 + EXTRA));
    check("b2b_aw_count", 64'(aw_hs - a0), 64'd1);
    check("b2b_w_count", 64'(w_hs - w0), 64'd1);
    check("b2b_ar_count", 64'(ar_hs - r0), 64'd1);
    check("b2b_ready_pulses", 64'(rdy_cnt - y0), 64'd2);
    check("b2b_araddr", 64'(cap_araddr), 64'h0104);

    // reset while o_arvalid is high
    v = vecs[0];
    v.ar_d = 20;
    set_slave(v);
    r0 = ar_hs; y0 = rdy_cnt;
    @(negedge clk);
    i_bus_valid = 1'b1; i_bus_access = 2'b10; i_bus_address = 16'h0200;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (o_arvalid) seen = 1;
      else @(negedge clk);
    end
    check("rst_arvalid_seen", 64'(seen), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear",
          64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_bus_ready}), 64'd0);
    i_bus_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("rst_abandoned_no_ready", 64'(rdy_cnt - y0), 64'd0);
    check("rst_abandoned_no_ar", 64'(ar_hs - r0), 64'd0);
    v = vecs[0];
    v.addr = 16'h0204; v.rdata = 32'h5555_AAAA; v.exp_rd = 32'h5555_AAAA;
    v.exp_lat = 3 + EXTRA;
    run_vec(v, "post_rst");

    // randomized requests against the reference model
    for (int i = 0; i < 24; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = 16'($urandom) & 16'hFFFC;
      v.wdata = $urandom;
      v.strb  = 4'($urandom);
      v.aw_d  = $urandom_range(0, 3);
      v.w_d   = $urandom_range(0, 3);
      v.b_d   = $urandom_range(0, 3);
      v.ar_d  = $urandom_range(0, 3);
      v.r_d   = $urandom_range(0, 3);
      v.resp  = 2'($urandom);
      v.rdata = $urandom;
      v.exp_st  = v.resp;
      v.exp_rd  = v.wr ? 32'h0 : v.rdata;
      v.exp_lat = model_lat(v);
      run_vec(v, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) go_idle();
    end

    check("payload_stability_errors", 64'(stab_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rggen_axi4lite_bridge.md
Name: rggen_axi4lite_bridge

Overview:
- Initiator-side counterpart of the AXI4-Lite register adapter.
- Converts one rggen native bus request (valid/access/address/write_data/strobe → ready/status/read_data) into one AXI4-Lite master transaction.
- Sits between an internal rggen bus initiator (CPU shim, debug port, bus-split fabric) and an AXI4-Lite responder, e.g. a register block behind the AXI4-Lite adapter.
- Single outstanding transaction; no reordering.

Parameters:
- ID_WIDTH, 0, AXI ID width; 0 means no ID, ports clipped to 1 bit and tied 0.
- ADDRESS_WIDTH, 16, bus and AXI address width.
- BUS_WIDTH, 32, data width; must be 32 or 64.
- ID_VALUE, 0, constant driven on o_awid/o_arid.
- PROT_VALUE, 3'b000, constant driven on o_awprot/o_arprot.
- ACTUAL_ID_WIDTH, max(ID_WIDTH,1), derived; do not override.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_bus_valid  in  1  request valid; held until o_bus_ready
- i_bus_access  in  2  bit0=1 write (2'b11), bit0=0 read (2'b10)
- i_bus_address  in  ADDRESS_WIDTH  byte address
- i_bus_write_data  in  BUS_WIDTH  write data
- i_bus_strobe  in  BUS_WIDTH/8  byte enables
- o_bus_ready  out  1  one-cycle completion pulse
- o_bus_status  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
- o_bus_read_data  out  BUS_WIDTH  read data; 0 for writes
- o_awvalid/i_awready, o_awid[ACTUAL_ID_WIDTH], o_awaddr[ADDRESS_WIDTH], o_awprot[3]  AW channel
- o_wvalid/i_wready, o_wdata[BUS_WIDTH], o_wstrb[BUS_WIDTH/8]  W channel
- i_bvalid/o_bready, i_bid[ACTUAL_ID_WIDTH] (ignored), i_bresp[2]  B channel
- o_arvalid/i_arready, o_arid, o_araddr, o_arprot  AR channel
- i_rvalid/o_rready, i_rid (ignored), i_rresp[2], i_rdata[BUS_WIDTH]  R channel

Behaviour:
- Reset (async): state IDLE; all AXI valids, o_bready, o_rready, o_bus_ready = 0. o_bus_status = 2'b00 and o_bus_read_data = 0 when registered.
- FSM states:
  - IDLE: when i_bus_valid=1, register address, data, strobe and access. Go to WRITE if access[0]=1, else READ. Next cycle assert o_awvalid+o_wvalid (WRITE) or o_arvalid (READ).
  - WRITE: o_awvalid and o_wvalid are independent. Each drops in the cycle after its own handshake and never reasserts for this transaction. AW and W may complete in either order or together. o_bready=1 throughout WRITE.
  - WRITE → RESP: on i_bvalid&&o_bready. A B response before both AW and W handshakes is protocol violation and is not checked.
  - READ: o_arvalid held until i_arready, then drops. o_rready=1 throughout READ. Go to RESP on i_rvalid&&o_rready.
  - RESP → IDLE: in the o_bus_ready cycle.
- Valid rules: AXI valids never depend combinationally on ready. Payloads stay stable while valid is high.
- Response mapping: bresp/rresp pass straight to o_bus_status. Read data comes from i_rdata. o_bus_read_data = 0 on writes.
- Back-to-back: IDLE accepts a new request in the cycle after o_bus_ready. Minimum read latency (i_bus_valid to o_bus_ready, ready slaves) = 3 cycles default.
- A request is never issued twice. A request captured in IDLE is always completed.
- i_bus_valid dropping mid-transaction (protocol violation) is ignored.
- Reset mid-transaction abandons it. Outputs return to reset values immediately.

Optional Feature:
- Macro: RGGEN_AXI4LITE_BRIDGE_RESPONSE_REG_EN.
- Undefined (default):
  - RESP is folded into WRITE/READ.
  - o_bus_ready = i_bvalid&&o_bready or i_rvalid&&o_rready, combinational.
  - status/read_data combinational from the B/R channel.
  - Latency = 2 + slave latency.
- Defined:
  - Response is captured into flops on the B/R handshake.
  - o_bus_ready, o_bus_status, o_bus_read_data are driven from flops one cycle later (RESP state).
  - Adds 1 cycle; breaks the AXI→bus timing path.

Test Plan:
- Read, slave always ready: address 0x0010, rdata 0xDEADBEEF, rresp 00 → one AR handshake with araddr 0x0010; o_bus_ready pulses once with read_data 0xDEADBEEF, status 00; latency 3 (4 with macro).
- Write, AW ready 2 cycles before W: data 0x12345678, strobe 4'b0011 → wdata/wstrb match; each valid drops after its own handshake; bresp 10 → status 10, read_data 0.
- Write, AW and W both stalled 5 cycles then ready together: exactly one AW and one W handshake, payloads stable throughout.
- Back-to-back write then read with i_bus_valid held across the ready cycle: the second request starts the cycle after o_bus_ready; exactly 2 AXI transactions.
- DECERR read (rresp 11, rdata 0xFFFFFFFF) → status 11, data passed through. Reset asserted while o_arvalid=1 → all valids 0 asynchronously; the next request after reset completes normally.
